mult_seq_param: RTL

- Parametrised iterative shift-add multiplier: WIDTH x WIDTH operands, 2*WIDTH product, BPC multiplier bits retired per clock.
- Runtime signed/unsigned mode; valid/ready handshake on both input and output sides.
- Next-generation arithmetic core for the datapath; drop-in successor to the fixed 64-bit unsigned sequential multiplier, with back-pressure and a result-hold stage.

---
 rtl/mult_seq_pkg.sv | 30 +++
 rtl/mult_seq_pp.sv | 25 ++
 rtl/mult_seq_param.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared types and helpers for the sequential multiplier.
//   state_t    : controller states (IDLE, RUN, SIGN, DONE)
//   cnt_width  : width of an iteration counter that must hold 0..n
//   cond_abs   : conditional two's-complement magnitude of a w-bit value
package mult_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

  // Widest operand cond_abs can handle; operands are zero-extended into it.
  localparam int ABS_MAX_W = 256;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Magnitude of the low w bits of v when en is set and bit w-1 is set,
  // otherwise the low w bits unchanged. |-2^(w-1)| = 2^(w-1) still fits
  // in w unsigned bits, so there is no overflow case.
  function automatic logic [ABS_MAX_W-1:0] cond_abs(
    input logic [ABS_MAX_W-1:0] v,
    input int                   w,
    input logic                 en
  );
    logic [ABS_MAX_W-1:0] mask;
    mask = {ABS_MAX_W{1'b1}} >> (ABS_MAX_W - w);
    if (en && v[w-1]) return (~v + ABS_MAX_W'(1)) & mask;
    else              return v & mask;
  endfunction

endpackage

// File: rtl/mult_seq_pp.sv
// mult_seq_pp: one shift-add step of the sequential multiplier.
//   acc         in  2*WIDTH  running sum
//   mcand_shift in  2*WIDTH  multiplicand aligned to the current digit
//   digit       in  BPC      current multiplier digit (unsigned)
//   acc_next    out 2*WIDTH  acc + mcand_shift*digit, modulo 2^(2*WIDTH)
module mult_seq_pp #(
  parameter int WIDTH = 64,
  parameter int BPC   = 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand_shift,
  input  logic [BPC-1:0]     digit,
  output logic [2*WIDTH-1:0] acc_next
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] pp;

  always_comb begin
    pp       = mcand_shift * PW'(digit);
    acc_next = acc + pp;
  end

endmodule

// File: rtl/mult_seq_param.sv
// mult_seq_param: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
// retiring BPC multiplier bits per clock, runtime signed/unsigned mode,
// valid/ready on both sides with the result held until consumed.
//   clk, reset (async, active-high)
//   in_valid/in_ready, is_signed, a_in, b_in  : operand handshake
//   out_valid/out_ready, product_out          : result handshake
//   busy                                      : high outside IDLE
// Optional build macro MULT_SEQ_EARLY_EXIT_EN: leave RUN as soon as the
// remaining multiplier bits are all zero (data-dependent latency). Without
// it every product takes exactly WIDTH/BPC RUN cycles.
module mult_seq_param
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product_out,
  output logic               busy
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = cnt_width(N);
  localparam int PW = 2 * WIDTH;

  if (WIDTH < 2) begin : g_bad_width
    $error("mult_seq_param: WIDTH must be at least 2");
  end
  if (BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_bpc
    $error("mult_seq_param: BPC must divide WIDTH");
  end
  if (WIDTH > ABS_MAX_W) begin : g_too_wide
    $error("mult_seq_param: WIDTH exceeds ABS_MAX_W");
  end

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc, acc_next, mcand_shift, product;
  logic [WIDTH-1:0] mplier, mplier_shr, a_abs, b_abs;
  logic            neg, last_iter;

  assign a_abs = WIDTH'(cond_abs(ABS_MAX_W'(a_in), WIDTH, is_signed));
  assign b_abs = WIDTH'(cond_abs(ABS_MAX_W'(b_in), WIDTH, is_signed));

  assign mplier_shr = mplier >> BPC;

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // Nothing left to add once the shifted-out multiplier is zero.
  assign last_iter = (cnt == CW'(N - 1)) || (mplier_shr == '0);
`else
  assign last_iter = (cnt == CW'(N - 1));
`endif

  mult_seq_pp #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_pp (
    .acc         (acc),
    .mcand_shift (mcand_shift),
    .digit       (mplier[BPC-1:0]),
    .acc_next    (acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN:  if (last_iter) state_next = SIGN;
      SIGN: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: magnitudes are multiplied unsigned, the sign is applied once
  // in SIGN, and product stays untouched through DONE for back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      acc         <= '0;
      mcand_shift <= '0;
      mplier      <= '0;
      neg         <= 1'b0;
      product     <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          mcand_shift <= PW'(a_abs);
          mplier      <= b_abs;
          neg         <= is_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          acc         <= '0;
          cnt         <= '0;
        end
        RUN: begin
          acc         <= acc_next;
          mcand_shift <= mcand_shift << BPC;
          mplier      <= mplier_shr;
          cnt         <= cnt + CW'(1);
        end
        SIGN:    product <= neg ? (~acc + PW'(1)) : acc;
        default: ;
      endcase
    end
  end

  assign product_out = product;

endmodule
